// File: rtl/nf_coeff_loader.sv
// -----------------------------------------------------------------------------
// nf_coeff_loader
//   Double-buffered coefficient store for the null-former FIR bank. The host
//   writes a shadow bank one word at a time. A commit arms a transfer that
//   copies the whole shadow bank into the active bank on the next
//   swap_strobe. If no strobe arrives within TIMEOUT cycles, the transfer is
//   forced and timeout_err is raised. The active bank is copied in a single
//   edge, so the null-former never sees a mix of old and new coefficients.
//
// Ports
//   clk, resetn     single clock, asynchronous active-low reset
//   wr_en/addr/data host coefficient write (index = channel_slot*NT + tap)
//   wr_ready        writes are accepted (no commit outstanding)
//   commit          arm shadow -> active transfer
//   swap_strobe     safe-update point from sample/frame timing
//   err_clr         clear sticky error flags
//   coeffs_concat   active bank, word k at [(k+1)*COEFF_WIDTH-1 : k*COEFF_WIDTH]
//   swap_done       one-cycle pulse after each completed swap
//   pending         a commit is waiting for its swap
//   addr_err        sticky: out-of-range write seen
//   timeout_err     sticky: swap was forced by timeout
//   swap_cnt        completed-swap count (wraps)
// -----------------------------------------------------------------------------
module nf_coeff_loader #(
  parameter  int NCH         = 4,
  parameter  int NT          = 8,
  parameter  int COEFF_WIDTH = 16,
  parameter  int TIMEOUT     = 1024,
  localparam int NCOEF       = (NCH - 1) * NT,
  localparam int ADDR_W      = (NCOEF > 1) ? $clog2(NCOEF) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  output logic                         wr_ready,
  input  logic                         commit,
  input  logic                         swap_strobe,
  input  logic                         err_clr,
  output logic [NCOEF*COEFF_WIDTH-1:0] coeffs_concat,
  output logic                         swap_done,
  output logic                         pending,
  output logic                         addr_err,
  output logic                         timeout_err,
  output logic [15:0]                  swap_cnt
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, PEND} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [COEFF_WIDTH-1:0]  shadow_q [NCOEF];
  logic [COEFF_WIDTH-1:0]  active_q [NCOEF];
  logic                    swap_done_q;
  logic                    addr_err_q;
  logic                    timeout_err_q;
  logic [15:0]             swap_cnt_q;

  logic in_range;
  logic wr_ok;
  logic wr_bad;
  logic do_swap;
  logic timed_out;

  assign in_range = (32'(wr_addr) < NCOEF);
  assign wr_ok    = (state_q == IDLE) && wr_en && in_range;
  assign wr_bad   = (state_q == IDLE) && wr_en && !in_range;

  // Next-state logic. Writes are only honoured in IDLE, so a write and a
  // swap can never land on the same edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_swap   = 1'b0;
    timed_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (commit) begin
          state_d = PEND;
          cnt_d   = '0;
        end
      end
      PEND: begin
        if (swap_strobe) begin
          do_swap = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Counter has run TIMEOUT PEND cycles without a strobe.
          do_swap   = 1'b1;
          timed_out = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: both banks are register files that must read as zero after reset
  // (the null-former consumes them directly), so they are reset word by word
  // rather than left as uninitialised storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NCOEF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      if (wr_ok) shadow_q[wr_addr] <= wr_data;
      if (do_swap) active_q <= shadow_q;
    end
  end

  // Status flags. A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      swap_done_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      swap_cnt_q    <= '0;
    end else begin
      swap_done_q <= do_swap;
      if (do_swap) swap_cnt_q <= swap_cnt_q + 16'd1;

      if (wr_bad)       addr_err_q <= 1'b1;
      else if (err_clr) addr_err_q <= 1'b0;

      if (timed_out)    timeout_err_q <= 1'b1;
      else if (err_clr) timeout_err_q <= 1'b0;
    end
  end

  // Outputs are plain decodes/copies of flops; nothing combinational from
  // inputs reaches an output.
  for (genvar g = 0; g < NCOEF; g++) begin : g_concat
    assign coeffs_concat[g*COEFF_WIDTH +: COEFF_WIDTH] = active_q[g];
  end

  assign wr_ready    = (state_q == IDLE);
  assign pending     = (state_q == PEND);
  assign swap_done   = swap_done_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = timeout_err_q;
  assign swap_cnt    = swap_cnt_q;

endmodule

// File: tb/tb_nf_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_nf_coeff_loader
//   Self-checking bench for nf_coeff_loader with NCH=4, NT=8, COEFF_WIDTH=16,
//   TIMEOUT=16 (NCOEF=24). A small reference model tracks the shadow bank and
//   the IDLE/PEND status; each accepted commit pushes the expected bank into
//   a queue, which a monitor pops on every swap_done pulse.
// -----------------------------------------------------------------------------
module tb_nf_coeff_loader;

  localparam int NCH   = 4;
  localparam int NT    = 8;
  localparam int CW    = 16;
  localparam int TMO   = 16;
  localparam int NCOEF = (NCH - 1) * NT;
  localparam int AW    = 5;
  localparam int BW    = NCOEF * CW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          wr_ready;
  logic          commit;
  logic          swap_strobe;
  logic          err_clr;
  logic [BW-1:0] coeffs_concat;
  logic          swap_done;
  logic          pending;
  logic          addr_err;
  logic          timeout_err;
  logic [15:0]   swap_cnt;

  nf_coeff_loader #(
    .NCH(NCH), .NT(NT), .COEFF_WIDTH(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .commit(commit), .swap_strobe(swap_strobe), .err_clr(err_clr),
    .coeffs_concat(coeffs_concat), .swap_done(swap_done), .pending(pending),
    .addr_err(addr_err), .timeout_err(timeout_err), .swap_cnt(swap_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [CW-1:0] m_shadow [NCOEF];
  logic [BW-1:0] m_active;
  logic          m_pend;
  int            m_cnt;
  logic [BW-1:0] exp_q [$];

  task automatic check(input string name, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_shadow();
    logic [BW-1:0] v;
    for (int k = 0; k < NCOEF; k++) v[k*CW +: CW] = m_shadow[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCOEF; k++) m_shadow[k] = '0;
    m_active = '0;
    m_pend   = 1'b0;
    m_cnt    = 0;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the edge.
  task automatic cyc(input logic we, input int addr, input logic [CW-1:0] data,
                     input logic cm, input logic sb, input logic clr);
    wr_en       = we;
    wr_addr     = AW'(addr);
    wr_data     = data;
    commit      = cm;
    swap_strobe = sb;
    err_clr     = clr;
    @(posedge clk);
    if (!m_pend) begin
      if (we && addr < NCOEF) m_shadow[addr] = data;
      if (cm) begin
        m_pend = 1'b1;
        m_cnt  = 0;
        exp_q.push_back(pack_shadow());
      end
    end else if (sb || m_cnt == TMO - 1) begin
      m_pend = 1'b0;
    end else begin
      m_cnt++;
    end
    #1;
    wr_en = 1'b0; commit = 1'b0; swap_strobe = 1'b0; err_clr = 1'b0;
  endtask

  // Scoreboard monitor: every swap_done pulse must match a queued commit.
  always @(negedge clk) begin
    if (resetn && swap_done) begin
      if (exp_q.size() == 0) begin
        check("swap_done_spurious", BW'(swap_done), BW'(0));
      end else begin
        m_active = exp_q.pop_front();
        check("swap_bank", coeffs_concat, m_active);
      end
    end
  end

  typedef struct {
    logic we; int addr; logic [CW-1:0] data; logic cm; logic sb; logic clr;
    logic exp_pend; logic exp_aerr; logic exp_done;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Address-error / PEND-gating table
    vecs[0] = '{1'b0,  0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // strobe in IDLE
    vecs[1] = '{1'b1, 24, 16'hDEAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // addr 24
    vecs[2] = '{1'b0,  0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // clear
    vecs[3] = '{1'b1, 31, 16'hCAFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}; // set beats clear
    vecs[4] = '{1'b1,  2, 16'h0A0A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // valid + clear
    vecs[5] = '{1'b0,  0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // commit
    vecs[6] = '{1'b1,  3, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // write in PEND
    vecs[7] = '{1'b1, 31, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // bad addr in PEND
    vecs[8] = '{1'b0,  0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // commit in PEND
    vecs[9] = '{1'b0,  0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // strobe swap

    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; swap_strobe = 1'b0; err_clr = 1'b0;
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_wr_ready",    BW'(wr_ready),    BW'(1));
    check("rst_pending",     BW'(pending),     BW'(0));
    check("rst_swap_done",   BW'(swap_done),   BW'(0));
    check("rst_addr_err",    BW'(addr_err),    BW'(0));
    check("rst_timeout_err", BW'(timeout_err), BW'(0));
    check("rst_swap_cnt",    BW'(swap_cnt),    BW'(0));
    check("rst_coeffs",      coeffs_concat,    BW'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Full-bank load, commit, strobe five cycles later
    for (int k = 0; k < NCOEF; k++) cyc(1'b1, k, CW'(k + 1), 1'b0, 1'b0, 1'b0);
    check("load_coeffs_untouched", coeffs_concat, BW'(0));
    cyc(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    check("commit_pending",  BW'(pending),  BW'(1));
    check("commit_wr_ready", BW'(wr_ready), BW'(0));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
      check("pend_coeffs_hold", coeffs_concat, BW'(0));
    end
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    check("strobe_swap_done", BW'(swap_done), BW'(1));
    check("strobe_pending",   BW'(pending),   BW'(0));
    check("strobe_swap_cnt",  BW'(swap_cnt),  BW'(1));
    check("strobe_word23",    BW'(coeffs_concat[23*CW +: CW]), BW'(24));
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    check("strobe_pulse_end", BW'(swap_done), BW'(0));

    // Timeout-forced swap
    cyc(1'b1,  5, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 23, 16'h8001, 1'b0, 1'b0, 1'b0);
    cyc(1'b0,  0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
      check("tmo_still_pending", BW'(pending),     BW'(1));
      check("tmo_no_err_yet",    BW'(timeout_err), BW'(0));
    end
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    check("tmo_forced_done", BW'(swap_done),   BW'(1));
    check("tmo_pending",     BW'(pending),     BW'(0));
    check("tmo_err_set",     BW'(timeout_err), BW'(1));
    check("tmo_swap_cnt",    BW'(swap_cnt),    BW'(2));
    check("tmo_word5",       BW'(coeffs_concat[5*CW +: CW]), BW'(16'hBEEF));
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b1);
    check("tmo_err_cleared", BW'(timeout_err), BW'(0));

    // Table: address errors, PEND gating, double commit
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cm, vecs[i].sb, vecs[i].clr);
      check($sformatf("vec%0d_pending", i),   BW'(pending),   BW'(vecs[i].exp_pend));
      check($sformatf("vec%0d_wr_ready", i),  BW'(wr_ready),  BW'(!vecs[i].exp_pend));
      check($sformatf("vec%0d_addr_err", i),  BW'(addr_err),  BW'(vecs[i].exp_aerr));
      check($sformatf("vec%0d_swap_done", i), BW'(swap_done), BW'(vecs[i].exp_done));
    end
    check("vec_swap_cnt", BW'(swap_cnt), BW'(3));
    check("vec_word3",    BW'(coeffs_concat[3*CW +: CW]), BW'(4));

    // Simultaneous write + commit, second commit ignored
    cyc(1'b1, 0, 16'h7FFF, 1'b1, 1'b0, 1'b0);
    check("wc_pending", BW'(pending), BW'(1));
    cyc(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    check("wc_swap_done", BW'(swap_done), BW'(1));
    check("wc_word0",     BW'(coeffs_concat[CW-1:0]), BW'(16'h7FFF));
    check("wc_swap_cnt",  BW'(swap_cnt),  BW'(4));
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    check("wc_single_pulse", BW'(swap_done), BW'(0));
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    check("wc_strobe_idle", BW'(swap_done), BW'(0));
    @(negedge clk);
    check("wc_queue_empty", BW'(exp_q.size()), BW'(0));
    @(posedge clk); #1;

    // Reset during PEND loses the commit
    cyc(1'b0, 0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_pending",  BW'(pending),       BW'(0));
    check("arst_coeffs",   coeffs_concat,      BW'(0));
    check("arst_swap_cnt", BW'(swap_cnt),      BW'(0));
    model_reset();
    @(negedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 0, '0, 1'b0, 1'b1, 1'b0);
    check("post_rst_no_swap",  BW'(swap_done), BW'(0));
    check("post_rst_pending",  BW'(pending),   BW'(0));
    check("post_rst_ready",    BW'(wr_ready),  BW'(1));
    check("post_rst_swap_cnt", BW'(swap_cnt),  BW'(0));
    check("post_rst_coeffs",   coeffs_concat,  BW'(0));
    cyc(1'b0, 0, '0, 1'b0, 1'b0, 1'b0);
    check("post_rst_no_pulse", BW'(swap_done), BW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
